// File: rtl/lfsr_word_server.sv
// lfsr_word_server
//
// Round-robin server that shares one Galois LFSR engine among NREQ
// requesters. A granted request runs the engine for OW serial steps. The
// output bits are collected LSB-first into an OW-bit word. The word is
// returned with a one-cycle, one-hot ack to the requester that was granted.
//
// Ports:
//   clk          clock, rising edge
//   arst         asynchronous, active-high reset
//   req          per-requester request, held until the matching ack
//   ack          one-hot, one-cycle pulse; data is valid while it is high
//   data         generated word (registered, held until the next completion)
//   grant_id     index of the current or last granted requester
//   busy         high while generating and during the ack cycle
//   seed_load    load seed into the engine (honoured only when idle)
//   seed         seed value; zero is replaced by SEED
//   lfsr_state   current engine state, for debug
//   words_served (only with LFSR_WORDS_SERVED_EN) wrapping count of
//                completed words
//
// Optional feature: define LFSR_WORDS_SERVED_EN to add the words_served
// output and its counter.

module lfsr_word_server #(
  parameter int            NREQ = 4,
  parameter int            W    = 8,
  parameter logic [W:0]    POLY = 9'h11D,
  parameter logic [W-1:0]  SEED = 8'h01,
  parameter int            OW   = 8,
  parameter int            IDW  = 2
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   ack,
  output logic [OW-1:0]     data,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
`ifdef LFSR_WORDS_SERVED_EN
  output logic [31:0]       words_served,
`endif
  input  logic              seed_load,
  input  logic [W-1:0]      seed,
  output logic [W-1:0]      lfsr_state
);

  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(OW - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(32'd1);
  localparam logic [NREQ-1:0] ACK_ONE  = NREQ'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One Galois step. Bit 0 of POLY is dropped, so a nonzero state never
  // maps to zero.
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    logic [W-1:0] shifted;
    shifted = {1'b0, s[W-1:1]};
    if (s[0]) begin
      return shifted ^ POLY[W:1];
    end else begin
      return shifted;
    end
  endfunction

  // (base + off) mod NREQ, with base and off both below NREQ.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                               input int off);
    int t;
    t = int'(base) + off;
    if (t >= NREQ) begin
      t = t - NREQ;
    end else begin
      t = t;
    end
    return IDW'(t);
  endfunction

  state_t          state_r, state_s;
  logic [W-1:0]    lfsr_r, lfsr_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [OW-1:0]   word_r, word_s;
  logic [OW-1:0]   data_r, data_s;
  logic [NREQ-1:0] ack_r, ack_s;
  logic [IDW-1:0]  grant_r, grant_s;
  logic [IDW-1:0]  rr_ptr_r, rr_ptr_s;
  logic            busy_r, busy_s;
  logic            found_s;
  logic [IDW-1:0]  pick_s;

  // Round-robin search that starts at rr_ptr and wraps modulo NREQ.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req[rr_index(rr_ptr_r, i)]) begin
        found_s = 1'b1;
        pick_s  = rr_index(rr_ptr_r, i);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_s  = state_r;
    lfsr_s   = lfsr_r;
    cnt_s    = cnt_r;
    word_s   = word_r;
    data_s   = data_r;
    ack_s    = '0;
    grant_s  = grant_r;
    rr_ptr_s = rr_ptr_r;
    case (state_r)
      ST_IDLE: begin
        // A seed load takes the cycle. Any pending grant waits one cycle.
        if (seed_load) begin
          lfsr_s = (seed == '0) ? SEED : seed;
        end else if (found_s) begin
          grant_s = pick_s;
          cnt_s   = '0;
          word_s  = '0;
          state_s = ST_GEN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GEN: begin
        lfsr_s        = lfsr_step(lfsr_r);
        word_s[cnt_r] = lfsr_r[0];
        cnt_s         = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          // The last bit is merged into data here, so data and ack become
          // valid together in the DONE cycle.
          data_s  = word_s;
          ack_s   = ACK_ONE << grant_r;
          state_s = ST_DONE;
        end else begin
          state_s = ST_GEN;
        end
      end
      ST_DONE: begin
        rr_ptr_s = rr_index(grant_r, 1);
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Engine, word assembly and registered outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      lfsr_r   <= SEED;
      cnt_r    <= '0;
      word_r   <= '0;
      data_r   <= '0;
      ack_r    <= '0;
      grant_r  <= '0;
      rr_ptr_r <= '0;
      busy_r   <= 1'b0;
    end else begin
      lfsr_r   <= lfsr_s;
      cnt_r    <= cnt_s;
      word_r   <= word_s;
      data_r   <= data_s;
      ack_r    <= ack_s;
      grant_r  <= grant_s;
      rr_ptr_r <= rr_ptr_s;
      busy_r   <= busy_s;
    end
  end

`ifdef LFSR_WORDS_SERVED_EN
  logic [31:0] served_r;

  // Count of completed words. It wraps naturally and is unaffected by seed
  // loads.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      served_r <= 32'd0;
    end else if (state_r == ST_DONE) begin
      served_r <= served_r + 32'd1;
    end else begin
      served_r <= served_r;
    end
  end

  assign words_served = served_r;
`endif

  assign ack        = ack_r;
  assign data       = data_r;
  assign grant_id   = grant_r;
  assign busy       = busy_r;
  assign lfsr_state = lfsr_r;

endmodule

// File: tb/tb_lfsr_word_server.sv
// Directed, table-driven bench for lfsr_word_server (default parameters:
// NREQ=4, W=8, POLY=0x11D, SEED=1, OW=8). Expected words were worked out
// by hand from the Galois step with feedback mask 0x8E.

module tb_lfsr_word_server;

  logic        clk;
  logic        arst;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [7:0]  data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        seed_load;
  logic [7:0]  seed;
  logic [7:0]  lfsr_state;
`ifdef LFSR_WORDS_SERVED_EN
  logic [31:0] words_served;
`endif

  int tests = 0;
  int fails = 0;

  lfsr_word_server dut (
    .clk        (clk),
    .arst       (arst),
    .req        (req),
    .ack        (ack),
    .data       (data),
    .grant_id   (grant_id),
    .busy       (busy),
`ifdef LFSR_WORDS_SERVED_EN
    .words_served(words_served),
`endif
    .seed_load  (seed_load),
    .seed       (seed),
    .lfsr_state (lfsr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       sl;
    logic [7:0] seed;
    logic [3:0] ack;
    logic [7:0] data;
    logic [7:0] st;
    logic [1:0] gid;
    int         cyc;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait on negedges for an ack, bounded by budget. seed_load is a
  // single-cycle strobe, so it is dropped after the first negedge.
  task automatic wait_ack(input int budget, output int cyc,
                          output logic [3:0] a);
    cyc = 0;
    a   = 4'b0000;
    while (cyc < budget && a == 4'b0000) begin
      @(negedge clk);
      cyc++;
      seed_load = 1'b0;
      a = ack;
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    req = 4'b0000;
    seed_load = 1'b0;
    seed = 8'h00;
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [3:0] a;
    logic [3:0] exp_ack [5];
    logic [7:0] exp_data [3];

    vecs[0] = '{req:4'b0001, sl:1'b0, seed:8'h00, ack:4'b0001, data:8'h8D, st:8'h83, gid:2'd0, cyc:9};
    vecs[1] = '{req:4'b0001, sl:1'b0, seed:8'h00, ack:4'b0001, data:8'h17, st:8'h16, gid:2'd0, cyc:9};
    vecs[2] = '{req:4'b0100, sl:1'b0, seed:8'h00, ack:4'b0100, data:8'hFE, st:8'hF5, gid:2'd2, cyc:9};
    vecs[3] = '{req:4'b0010, sl:1'b1, seed:8'h00, ack:4'b0010, data:8'h8D, st:8'h83, gid:2'd1, cyc:10};
    vecs[4] = '{req:4'b1000, sl:1'b1, seed:8'h55, ack:4'b1000, data:8'h29, st:8'h2A, gid:2'd3, cyc:10};
    exp_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_data = '{8'h8D, 8'h17, 8'hFE};

    arst = 1'b1;
    req = 4'b0000;
    seed_load = 1'b0;
    seed = 8'h00;
    #1;
    check("rst_ack", ack, 4'b0000);
    check("rst_data", data, 8'h00);
    check("rst_gid", grant_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", lfsr_state, 8'h01);
    do_reset();

    // Table of single requests, each followed by one idle cycle.
    for (int i = 0; i < 5; i++) begin
      req = vecs[i].req;
      seed_load = vecs[i].sl;
      seed = vecs[i].seed;
      wait_ack(30, cyc, a);
      check($sformatf("v%0d_ack", i), a, vecs[i].ack);
      check($sformatf("v%0d_cyc", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d_data", i), data, vecs[i].data);
      check($sformatf("v%0d_state", i), lfsr_state, vecs[i].st);
      check($sformatf("v%0d_gid", i), grant_id, vecs[i].gid);
      req = 4'b0000;
      @(negedge clk);
      check($sformatf("v%0d_ackclr", i), ack, 4'b0000);
      check($sformatf("v%0d_idle", i), busy, 1'b0);
    end

    // All four requesters held: strict round-robin, 10 cycles apart.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(30, cyc, a);
      check($sformatf("rr%0d_ack", k), a, exp_ack[k]);
      check($sformatf("rr%0d_cyc", k), cyc, (k == 0) ? 9 : 10);
      if (k < 3) begin
        check($sformatf("rr%0d_data", k), data, exp_data[k]);
      end else begin
        check($sformatf("rr%0d_busy", k), busy, 1'b1);
      end
    end
    req = 4'b0000;
    @(negedge clk);

    // Seed load during GEN is ignored. req dropped mid-word still completes.
    do_reset();
    req = 4'b0001;
    cyc = 0;
    a = 4'b0000;
    while (cyc < 30 && a == 4'b0000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("gen_busy", busy, 1'b1);
      if (cyc == 2) req = 4'b0000;
      seed_load = (cyc == 3);
      seed = 8'h55;
      a = ack;
    end
    seed_load = 1'b0;
    check("sl_gen_ack", a, 4'b0001);
    check("sl_gen_cyc", cyc, 9);
    check("sl_gen_data", data, 8'h8D);
    check("sl_gen_state", lfsr_state, 8'h83);
    @(negedge clk);

    // Reset in the middle of generation discards the partial word.
    do_reset();
    req = 4'b0001;
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    arst = 1'b1;
    #1;
    check("arst_ack", ack, 4'b0000);
    check("arst_busy", busy, 1'b0);
    check("arst_state", lfsr_state, 8'h01);
    @(negedge clk);
    check("arst_hold_ack", ack, 4'b0000);
    arst = 1'b0;
    wait_ack(30, cyc, a);
    check("post_arst_ack", a, 4'b0001);
    check("post_arst_cyc", cyc, 9);
    check("post_arst_data", data, 8'h8D);
    req = 4'b0000;
    @(negedge clk);

`ifdef LFSR_WORDS_SERVED_EN
    do_reset();
    check("ws_rst", words_served, 32'd0);
    for (int k = 0; k < 3; k++) begin
      req = 4'b0010;
      wait_ack(30, cyc, a);
      req = 4'b0000;
      @(negedge clk);
    end
    check("ws_three", words_served, 32'd3);
    force dut.served_r = 32'hFFFF_FFFF;
    #1;
    release dut.served_r;
    req = 4'b0001;
    wait_ack(30, cyc, a);
    req = 4'b0000;
    @(negedge clk);
    check("ws_wrap", words_served, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_word_server.md
Name: lfsr_word_server

Overview:
Round-robin server that shares one Galois LFSR engine among NREQ requesters. Each granted request runs the engine for OW serial steps and collects the output bits into an OW-bit random word. The word is returned to the granted requester with a one-cycle ack. The block sits between the serial PRBS datapath and consumers (scramblers, test-pattern sources) that need whole words on demand.

Parameters:
NREQ, 4, number of requesters (2..16)
W, 8, LFSR state width
POLY, 9'h11D, feedback polynomial of W+1 bits; the LSB is ignored
SEED, 1, reset state; also substituted for any all-zero seed load; must be nonzero
OW, 8, output word width (1..32)
IDW, 2, width of grant_id; must be at least clog2(NREQ)

Ports:
clk        in   1        clock, rising edge
arst       in   1        asynchronous, active-high reset
req        in   NREQ     request per requester; held high until the matching ack
ack        out  NREQ     one-hot, one-cycle pulse; data is valid while it is high
data       out  OW       generated word
grant_id   out  IDW      index of the current or last granted requester
busy       out  1        high in GEN and DONE
seed_load  in   1        load seed into the LFSR state (honoured only in IDLE)
seed       in   W        seed value
lfsr_state out  W        current engine state, for debug

Behaviour:
- Engine step: out_bit = s[0]. If s[0] is 1, s <= (s>>1) ^ (POLY>>1); otherwise s <= s>>1.
- Word assembly is LSB-first: data[k] = out_bit of step k, for k = 0..OW-1.
- Reset values: s=SEED, ack=0, data=0, grant_id=0, busy=0, rr_ptr=0, state=IDLE. All are asynchronous on arst.
- States:
  - IDLE:
    - seed_load=1: s <= (seed==0) ? SEED : seed. No grant is made that cycle; seed_load wins over a pending req.
    - Otherwise, if any req is high: grant the first set bit searching rr_ptr, rr_ptr+1, ... (mod NREQ). Set grant_id, clear the step counter, go to GEN.
  - GEN:
    - One engine step per cycle, for OW cycles (counter 0..OW-1).
    - After step OW-1, go to DONE.
  - DONE:
    - ack[grant_id]=1 for this single cycle; data holds the assembled word.
    - rr_ptr <= (grant_id+1) mod NREQ. Go to IDLE.
- Latency: req sampled in IDLE at cycle T; GEN covers T+1..T+OW; ack at T+OW+1. The earliest next grant is in IDLE at T+OW+2.
- data is registered and holds its value until the next DONE. ack is zero outside DONE.
- seed_load in GEN or DONE is ignored. No error is flagged.
- If req drops mid-generation, the word still completes and ack is still pulsed. The engine state advances regardless.
- A requester still high in the IDLE cycle after its ack counts as a new request. With others requesting, round-robin gives it lowest priority.
- Simultaneous requests are served strictly in round-robin order. No requester waits more than NREQ-1 services.
- arst mid-GEN: the partial word is discarded, no ack is issued, and s returns to SEED.
- The engine never reaches the all-zero state, because POLY's bit 0 is ignored and zero seeds are replaced by SEED.

Optional Feature:
Macro LFSR_WORDS_SERVED_EN.
- Defined: adds output port words_served, 32 bits wide, reset 0. It increments on every DONE cycle and wraps from 0xFFFFFFFF to 0. seed_load does not clear it.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Defaults, reset, then req=4'b0001 held → ack[0] pulses 9 cycles after sampling, data=0x8D, lfsr_state=0x83.
2. After test 1, req=4'b0001 again → data=0x17, lfsr_state=0x16.
3. After reset, req=4'b1111 held continuously → acks go to 0,1,2,3,0 in that order, each 10 cycles apart; first data 0x8D, second 0x17.
4. In IDLE, seed_load=1 with seed=0x00 and req=4'b0010 in the same cycle → s=0x01 (SEED), grant deferred one cycle, ack[1] data=0x8D. seed_load with seed=0x55 during GEN → ignored, word unaffected.
5. arst pulsed at step 4 of GEN → ack stays 0, busy=0, lfsr_state=0x01. The next request returns 0x8D.
6. LFSR_WORDS_SERVED_EN defined: 3 completed words → words_served=3. Force the counter to 0xFFFFFFFF and complete one word → words_served=0.
